// File: rtl/flight_input_pkg.sv
// Shared constants and types for the pilot input path.
package flight_input_pkg;

    localparam int unsigned THROTTLE_MAX        = 100;
    localparam int unsigned DEFAULT_INPUT_WIDTH = 8;

    // Handshake with plane_state: IDLE -> SNAP -> READY -> HOLD -> IDLE.
    typedef enum logic [1:0] {
        StIdle,
        StSnap,
        StReady,
        StHold
    } hs_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a hold-time debouncer for one raw button.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count while the synchronised level disagrees; flip once it has held long enough.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounced level and counter state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/pilot_input_controller.sv
// Turns six raw buttons into ramped pitch/roll rates and an integrated throttle,
// and hands a registered snapshot to plane_state on request.
module pilot_input_controller
    import flight_input_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH     = DEFAULT_INPUT_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_CYCLES     = 2500000,
    parameter int unsigned MAX_RATE        = 30,
    parameter int unsigned RATE_STEP       = 5,
    parameter int unsigned THROTTLE_RESET  = 50
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          btn_pitch_up_i,
    input  logic                          btn_pitch_down_i,
    input  logic                          btn_roll_left_i,
    input  logic                          btn_roll_right_i,
    input  logic                          btn_throttle_up_i,
    input  logic                          btn_throttle_down_i,
    input  logic                          request_input_i,
    output logic                          input_ready_o,
    output logic signed [INPUT_WIDTH-1:0] pitch_change_o,
    output logic signed [INPUT_WIDTH-1:0] roll_change_o,
    output logic        [INPUT_WIDTH:0]   throttle_o
);

    localparam int unsigned TW    = INPUT_WIDTH + 1;
    localparam int unsigned TickW = $clog2(TICK_CYCLES + 1);

    localparam logic signed [INPUT_WIDTH-1:0] MaxPos = INPUT_WIDTH'(MAX_RATE);
    localparam logic signed [INPUT_WIDTH-1:0] MaxNeg = -MaxPos;
    localparam logic signed [INPUT_WIDTH-1:0] StepN  = INPUT_WIDTH'(RATE_STEP);
    localparam logic signed [INPUT_WIDTH:0]   StepW  = TW'(RATE_STEP);

    // Bit order: pitch up, pitch down, roll right, roll left, throttle up, throttle down.
    logic [5:0] btn_raw, btn_db;
    assign btn_raw = {btn_throttle_down_i, btn_throttle_up_i, btn_roll_left_i,
                      btn_roll_right_i, btn_pitch_down_i, btn_pitch_up_i};

    for (genvar i = 0; i < 6; i++) begin : gen_db
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .btn_i  (btn_raw[i]),
            .level_o(btn_db[i])
        );
    end

    function automatic logic signed [INPUT_WIDTH-1:0] axis_target(input logic pos, input logic neg);
        if (pos && !neg) return MaxPos;
        if (neg && !pos) return MaxNeg;
        return '0;
    endfunction

    // One step toward the target, landing exactly on it when closer than a step.
    function automatic logic signed [INPUT_WIDTH-1:0] ramp(
        input logic signed [INPUT_WIDTH-1:0] cur,
        input logic signed [INPUT_WIDTH-1:0] tgt
    );
        logic signed [INPUT_WIDTH:0] diff;
        diff = {tgt[INPUT_WIDTH-1], tgt} - {cur[INPUT_WIDTH-1], cur};
        if (diff > StepW) return cur + StepN;
        if (diff < -StepW) return cur - StepN;
        return tgt;
    endfunction

    logic [TickW-1:0]              tick_cnt_q, tick_cnt_d;
    logic                          tick;
    logic signed [INPUT_WIDTH-1:0] pitch_q, pitch_d, roll_q, roll_d;
    logic        [TW-1:0]          thr_q, thr_d;

    assign tick = (tick_cnt_q == TickW'(TICK_CYCLES - 1));

    // Tick counter and live rate/throttle next-state.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        pitch_d    = pitch_q;
        roll_d     = roll_q;
        thr_d      = thr_q;
        if (tick) begin
            pitch_d = ramp(pitch_q, axis_target(btn_db[0], btn_db[1]));
            roll_d  = ramp(roll_q, axis_target(btn_db[2], btn_db[3]));
            if (btn_db[4] && !btn_db[5] && thr_q != TW'(THROTTLE_MAX)) begin
                thr_d = thr_q + 1'b1;
            end else if (btn_db[5] && !btn_db[4] && thr_q != '0) begin
                thr_d = thr_q - 1'b1;
            end
        end
    end

    // Live state, updated regardless of handshake state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tick_cnt_q <= '0;
            pitch_q    <= '0;
            roll_q     <= '0;
            thr_q      <= TW'(THROTTLE_RESET);
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pitch_q    <= pitch_d;
            roll_q     <= roll_d;
            thr_q      <= thr_d;
        end
    end

    hs_state_e state_q;

    // Handshake FSM with registered snapshot; ready is high exactly while in READY.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            input_ready_o  <= 1'b0;
            pitch_change_o <= '0;
            roll_change_o  <= '0;
            throttle_o     <= TW'(THROTTLE_RESET);
        end else begin
            input_ready_o <= 1'b0;
            unique case (state_q)
                StIdle:  if (request_input_i) state_q <= StSnap;
                StSnap: begin
                    pitch_change_o <= pitch_q;
                    roll_change_o  <= roll_q;
                    throttle_o     <= thr_q;
                    input_ready_o  <= 1'b1;
                    state_q        <= StReady;
                end
                StReady: state_q <= StHold;
                StHold:  if (!request_input_i) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pilot_input_controller.sv
// Scoreboard bench: each request pushes the expected snapshot, each input_ready pops it.
module tb_pilot_input_controller;

    localparam int unsigned W    = 8;
    localparam int          TICK = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pu = 1'b0, pd = 1'b0, rl = 1'b0, rr = 1'b0, tu = 1'b0, td = 1'b0;
    logic req = 1'b0;
    logic ready;
    logic signed [W-1:0] pitch, roll;
    logic [W:0] thr;

    pilot_input_controller #(
        .INPUT_WIDTH    (W),
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (TICK),
        .MAX_RATE       (30),
        .RATE_STEP      (10),
        .THROTTLE_RESET (50)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .btn_pitch_up_i     (pu),
        .btn_pitch_down_i   (pd),
        .btn_roll_left_i    (rl),
        .btn_roll_right_i   (rr),
        .btn_throttle_up_i  (tu),
        .btn_throttle_down_i(td),
        .request_input_i    (req),
        .input_ready_o      (ready),
        .pitch_change_o     (pitch),
        .roll_change_o      (roll),
        .throttle_o         (thr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    pitch;
        int    roll;
        int    thr;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   pulses = 0;
    int   cyc;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Cycles since reset release; the DUT ticks on edges where cyc goes 8n-1 -> 8n.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Pop and compare on every ready pulse.
    always @(negedge clk) begin
        if (ready) begin
            pulses++;
            if (q.size() == 0) begin
                check_eq("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_eq({e.tag, "_pitch"}, int'(pitch), e.pitch);
                check_eq({e.tag, "_roll"}, int'(roll), e.roll);
                check_eq({e.tag, "_thr"}, int'(thr), e.thr);
            end
        end
    end

    // Return just after the next edge on which the DUT applies a tick update.
    task automatic wait_tick();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % TICK != 0);
    endtask

    task automatic do_request(input string tag, input int ep, input int er, input int et);
        exp_t e;
        int   n;
        e.tag = tag; e.pitch = ep; e.roll = er; e.thr = et;
        q.push_back(e);
        req = 1'b1;
        n   = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 10);
        check_eq({tag, "_latency"}, n, 2);
        req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_ready_low"}, int'(ready), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", int'(ready), 0);
        check_eq("rst_pitch", int'(pitch), 0);
        check_eq("rst_roll", int'(roll), 0);
        check_eq("rst_thr", int'(thr), 50);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_request("reset_req", 0, 0, 50);

        // Pitch ramp up to the clamp, then back to zero.
        wait_tick();
        pu = 1'b1;
        wait_tick(); do_request("ramp_t1", 10, 0, 50);
        wait_tick(); do_request("ramp_t2", 20, 0, 50);
        wait_tick(); do_request("ramp_t3", 30, 0, 50);
        wait_tick();
        wait_tick();
        pu = 1'b0;
        do_request("ramp_t5", 30, 0, 50);
        repeat (3) wait_tick();
        do_request("ramp_release", 0, 0, 50);

        // Opposing pitch buttons decay the rate to zero.
        wait_tick();
        pu = 1'b1;
        wait_tick();
        wait_tick();
        pd = 1'b1;
        do_request("opp_start", 20, 0, 50);
        wait_tick(); do_request("opp_t1", 10, 0, 50);
        wait_tick(); do_request("opp_t2", 0, 0, 50);
        pu = 1'b0;
        pd = 1'b0;
        repeat (2) wait_tick();

        // Bouncing roll button never gets through.
        for (int i = 0; i < 20; i++) begin
            rl = ~rl;
            repeat (2) @(posedge clk);
            #1;
        end
        do_request("bounce", 0, 0, 50);
        wait_tick();
        rl = 1'b1;
        wait_tick();
        rl = 1'b0;
        do_request("roll_steady", 0, -10, 50);
        repeat (4) wait_tick();

        // Throttle saturation at both ends, then both buttons hold the value.
        wait_tick();
        tu = 1'b1;
        repeat (10) wait_tick();
        do_request("thr_up10", 0, 0, 60);
        repeat (50) wait_tick();
        do_request("thr_max", 0, 0, 100);
        wait_tick();
        tu = 1'b0;
        td = 1'b1;
        repeat (120) wait_tick();
        do_request("thr_min", 0, 0, 0);
        wait_tick();
        td = 1'b0;
        tu = 1'b1;
        repeat (20) wait_tick();
        td = 1'b1;
        do_request("thr_up20", 0, 0, 20);
        repeat (5) wait_tick();
        do_request("thr_both", 0, 0, 20);
        tu = 1'b0;
        td = 1'b0;
        repeat (2) wait_tick();

        // Long request yields one pulse; re-arm gives another.
        begin
            exp_t e;
            e.tag = "hs_long"; e.pitch = 0; e.roll = 0; e.thr = 20;
            q.push_back(e);
        end
        p0  = pulses;
        req = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("hs_one_pulse", pulses - p0, 1);
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_request("hs_rearm", 0, 0, 20);

        // Reset while READY clears ready and snapshot immediately.
        req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rdy_before_rst", int'(ready), 1);
        check_eq("thr_before_rst", int'(thr), 20);
        reset = 1'b1;
        #1;
        check_eq("rdy_in_rst", int'(ready), 0);
        check_eq("thr_in_rst", int'(thr), 50);
        check_eq("pitch_in_rst", int'(pitch), 0);
        check_eq("roll_in_rst", int'(roll), 0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_request("post_rst", 0, 0, 50);

        check_eq("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pilot_input_controller.md
Name: pilot_input_controller

Overview:
- Upstream producer for plane_state's pilot inputs: turns raw board buttons into pitch_change, roll_change and throttle.
- Synchronises and debounces six buttons, ramps the pitch/roll rates and integrates throttle on a slow tick.
- Serves the plane_state request_input/input_ready handshake with a registered snapshot, replacing the constant ties at top level.

Parameters:
- INPUT_WIDTH, 8: width of the signed rate outputs; throttle is INPUT_WIDTH+1 bits.
- DEBOUNCE_CYCLES, 500000: cycles a synchronised button must hold steady before its debounced level changes (10 ms at 50 MHz).
- TICK_CYCLES, 2500000: period of the ramp/throttle update tick (20 Hz).
- MAX_RATE, 30: magnitude limit of pitch_change and roll_change, in deg/sec.
- RATE_STEP, 5: rate change per tick while moving toward the target rate.
- THROTTLE_RESET, 50: throttle value after reset, in percent.

Ports:
- clk, in, 1: system clock (sys_clk).
- reset, in, 1: asynchronous, active-high reset.
- btn_pitch_up, in, 1: raw button, active-high, asynchronous to clk.
- btn_pitch_down, in, 1: as above.
- btn_roll_left, in, 1: as above.
- btn_roll_right, in, 1: as above.
- btn_throttle_up, in, 1: as above.
- btn_throttle_down, in, 1: as above.
- request_input, in, 1: level request from plane_state.
- input_ready, out, 1: one-cycle pulse; the snapshot outputs are valid.
- pitch_change, out, INPUT_WIDTH, signed: snapshot pitch rate, deg/sec; positive means nose up.
- roll_change, out, INPUT_WIDTH, signed: snapshot roll rate; positive means roll right.
- throttle, out, INPUT_WIDTH+1, unsigned: snapshot throttle, 0..100.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - all synchronisers, debounced levels and counters to 0;
  - live rates to 0 and live throttle to THROTTLE_RESET;
  - pitch_change = 0, roll_change = 0, throttle = THROTTLE_RESET, input_ready = 0;
  - FSM to IDLE.
- Synchronise each button through 2 flip-flops.
- Debounce:
  - Each button has a counter that counts while the synchronised level differs from the debounced level.
  - The debounced level flips when the count reaches DEBOUNCE_CYCLES; the counter then clears.
  - Any return to equality clears the counter.
  - Worst-case pin-to-debounced latency is DEBOUNCE_CYCLES+3 cycles.
- Tick: a free-running counter 0..TICK_CYCLES-1; tick is high for 1 cycle when the counter wraps.
- Rate target, per axis:
  - only the positive button held → +MAX_RATE;
  - only the negative button held → -MAX_RATE;
  - neither or both held → 0.
- Rate update: on each tick the live rate moves toward its target by RATE_STEP, clamped so it never overshoots. A live rate equal to its target is unchanged.
- Throttle update, on each tick:
  - only up held → +1, saturating at 100;
  - only down held → -1, saturating at 0;
  - both or neither held → unchanged.
- Handshake FSM:
  - IDLE: if request_input=1, go to SNAP.
  - SNAP: register the live rate and throttle values into the output ports; go to READY.
  - READY: input_ready=1 for this cycle only; go to HOLD.
  - HOLD: wait until request_input=0, then go to IDLE.
  - Latency from request_input rising to input_ready is 2 cycles.
  - A tick in the SNAP cycle is not reflected in the snapshot; it appears in the next one.
  - Output ports change only in SNAP and are otherwise held stable.
  - Live state keeps updating in every FSM state.
  - A request held high produces exactly one input_ready.
  - Reset in any state returns to IDLE with input_ready=0.

Decomposition:
- Package flight_input_pkg:
  - THROTTLE_MAX = 100;
  - typedef of the handshake state enum (IDLE, SNAP, READY, HOLD);
  - localparam for the default INPUT_WIDTH.
- One sub-module, button_debouncer (synchroniser plus counter, parameter DEBOUNCE_CYCLES), instantiated 6 times.

Test Plan (DEBOUNCE_CYCLES=4, TICK_CYCLES=8, MAX_RATE=30, RATE_STEP=10):
- Reset then request: pulse reset, then raise request_input → input_ready at +2 cycles with pitch_change=0, roll_change=0, throttle=50.
- Rate ramp: hold btn_pitch_up for 5 ticks; sample after ticks 1, 2, 3 and 5 → pitch_change=10, 20, 30, 30. Release and wait 3 ticks → pitch_change=0.
- Bounce rejection:
  - toggle btn_roll_left every 2 cycles for 40 cycles → roll_change stays 0;
  - hold it steady → roll_change reaches -10 within 4+3+8 cycles.
- Throttle saturation:
  - hold btn_throttle_up for 60 ticks → throttle=100, not 101 or a wrapped value;
  - hold btn_throttle_down for 120 ticks → throttle=0;
  - hold both buttons → throttle unchanged.
- Opposing axis buttons: hold pitch_up and pitch_down together from pitch_change=+20 → decays to 10 then 0 over 2 ticks.
- Handshake:
  - hold request_input high for 20 cycles → exactly one input_ready pulse;
  - drop then re-raise request_input → second pulse 2 cycles later;
  - assert reset in READY → input_ready=0 immediately and outputs return to their reset values.
